// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF neuron layer.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lif_state_e;

  localparam logic RESET_SUBTRACT = 1'b0;
  localparam logic RESET_ZERO     = 1'b1;

endpackage

// File: rtl/lif_update_unit.sv
// Combinational single-neuron LIF update: leak, saturating integrate, fire and reset.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int STATE_W = 8
) (
  input  logic [STATE_W-1:0] mem,
  input  logic [STATE_W-1:0] cur,
  input  logic [STATE_W-1:0] beta,
  input  logic [STATE_W-1:0] threshold,
  input  logic               mode,
  output logic [STATE_W-1:0] mem_next,
  output logic               spike
);

  localparam logic [2*STATE_W-1:0] SAT = {{STATE_W{1'b0}}, {STATE_W{1'b1}}};

  logic [2*STATE_W-1:0] prod;
  logic [2*STATE_W-1:0] sum_w;
  logic [STATE_W-1:0]   v;

  assign prod  = {{STATE_W{1'b0}}, mem} * {{STATE_W{1'b0}}, beta};
  // Sum is kept wide so the saturation compare sees every carry bit.
  assign sum_w = (prod >> STATE_W) + {{STATE_W{1'b0}}, cur};
  assign v     = (sum_w > SAT) ? {STATE_W{1'b1}} : sum_w[STATE_W-1:0];
  assign spike = (v >= threshold);

  always_comb begin
    mem_next = v;
    if (spike) begin
      mem_next = (mode == RESET_ZERO) ? '0 : v - threshold;
    end
  end

endmodule

// File: rtl/lif_layer.sv
// Layer of N_NEURONS LIF neurons sharing one sequential update datapath.
// Optional refractory counters enabled by defining LIF_REFRACTORY_EN.
//
// state | meaning
// IDLE  | ready for a step; accept captures current/beta/threshold
// RUN   | update neuron idx, one per clock
// DONE  | spike vector and spike_valid presented, return to IDLE
module lif_layer
  import lif_pkg::*;
#(
  parameter int N_NEURONS    = 8,
  parameter int STATE_W      = 8,
  parameter int RESET_MODE   = 0,
  parameter int REFRAC_STEPS = 2,
  localparam int SEL_W       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         step_valid,
  output logic                         step_ready,
  input  logic [N_NEURONS*STATE_W-1:0] current,
  input  logic [STATE_W-1:0]           beta,
  input  logic [STATE_W-1:0]           threshold,
  output logic [N_NEURONS-1:0]         spikes,
  output logic                         spike_valid,
  input  logic [SEL_W-1:0]             mon_sel,
  output logic [STATE_W-1:0]           state_mon
);

  if (N_NEURONS < 1 || REFRAC_STEPS < 0) begin : g_param_check
    $error("lif_layer: N_NEURONS must be >= 1 and REFRAC_STEPS >= 0");
  end

  lif_state_e state_q, state_d;

  logic [SEL_W-1:0]             idx_q;
  logic [N_NEURONS*STATE_W-1:0] cur_sh;
  logic [STATE_W-1:0]           beta_sh;
  logic [STATE_W-1:0]           thr_sh;
  logic [STATE_W-1:0]           mem_q [N_NEURONS];
  logic [N_NEURONS-1:0]         stage_q;
  logic [N_NEURONS-1:0]         stage_next;

  logic               accept;
  logic               last;
  logic [STATE_W-1:0] mem_sel;
  logic [STATE_W-1:0] cur_sel;
  logic [STATE_W-1:0] upd_mem;
  logic               upd_spike;
  logic [STATE_W-1:0] commit_mem;
  logic               commit_spike;

  assign accept    = step_valid && step_ready;
  assign last      = (idx_q == SEL_W'(N_NEURONS - 1));
  assign mem_sel   = mem_q[idx_q];
  assign cur_sel   = cur_sh[idx_q*STATE_W +: STATE_W];
  assign state_mon = mem_q[mon_sel];

  lif_update_unit #(
    .STATE_W(STATE_W)
  ) u_update (
    .mem      (mem_sel),
    .cur      (cur_sel),
    .beta     (beta_sh),
    .threshold(thr_sh),
    .mode     ((RESET_MODE != 0) ? RESET_ZERO : RESET_SUBTRACT),
    .mem_next (upd_mem),
    .spike    (upd_spike)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  logic [RC_W-1:0] refrac_q [N_NEURONS];
  logic            in_refrac;

  assign in_refrac = (refrac_q[idx_q] != '0);

  always_comb begin
    commit_mem   = upd_mem;
    commit_spike = upd_spike;
    if (in_refrac) begin
      commit_mem   = mem_sel;
      commit_spike = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) refrac_q[i] <= '0;
    end else if (state_q == RUN) begin
      if (in_refrac) begin
        refrac_q[idx_q] <= refrac_q[idx_q] - RC_W'(1);
      end else if (upd_spike) begin
        refrac_q[idx_q] <= RC_W'(REFRAC_STEPS);
      end
    end
  end
`else
  assign commit_mem   = upd_mem;
  assign commit_spike = upd_spike;
`endif

  always_comb begin
    stage_next        = stage_q;
    stage_next[idx_q] = commit_spike;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_ready = 1'b0;
    case (state_q)
      IDLE: begin
        step_ready = 1'b1;
        if (step_valid) state_d = RUN;
      end
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last neuron's result goes straight into spikes so the vector and
  // spike_valid are both registered and visible for the whole DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q       <= '0;
      cur_sh      <= '0;
      beta_sh     <= '0;
      thr_sh      <= '0;
      stage_q     <= '0;
      spikes      <= '0;
      spike_valid <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) mem_q[i] <= '0;
    end else begin
      spike_valid <= 1'b0;
      if (accept) begin
        cur_sh  <= current;
        beta_sh <= beta;
        thr_sh  <= threshold;
        idx_q   <= '0;
      end
      if (state_q == RUN) begin
        mem_q[idx_q] <= commit_mem;
        stage_q      <= stage_next;
        idx_q        <= idx_q + SEL_W'(1);
        if (last) begin
          spikes      <= stage_next;
          spike_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lif_layer.sv
// Scoreboard bench for lif_layer: random and directed steps against an arithmetic LIF model.
module tb_lif_layer;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int RM   = 0;
  localparam int RS   = 2;
  localparam int SW   = 2;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           step_valid = 1'b0;
  logic           step_ready;
  logic [N*W-1:0] current = '0;
  logic [W-1:0]   beta = '0;
  logic [W-1:0]   threshold = '0;
  logic [N-1:0]   spikes;
  logic           spike_valid;
  logic [SW-1:0]  mon_sel = '0;
  logic [W-1:0]   state_mon;

  always #5 clk = ~clk;

  lif_layer #(
    .N_NEURONS(N), .STATE_W(W), .RESET_MODE(RM), .REFRAC_STEPS(RS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_valid(step_valid), .step_ready(step_ready),
    .current(current), .beta(beta), .threshold(threshold), .spikes(spikes),
    .spike_valid(spike_valid), .mon_sel(mon_sel), .state_mon(state_mon)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int mem_m[N];
  int ref_m[N];
  logic [N-1:0] exp_q[$];
  logic [N-1:0] e_spk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mem_m[i] = 0;
      ref_m[i] = 0;
    end
  endtask

  // One layer step computed neuron by neuron from the LIF equations.
  function automatic logic [N-1:0] model_step(input logic [N*W-1:0] cur_v, input int b, input int t);
    logic [N-1:0] s;
    int c, v;
    s = '0;
    for (int i = 0; i < N; i++) begin
      c = int'(cur_v[i*W +: W]);
`ifdef LIF_REFRACTORY_EN
      if (ref_m[i] > 0) begin
        ref_m[i] = ref_m[i] - 1;
        continue;
      end
`endif
      v = (mem_m[i] * b) / (MAXV + 1) + c;
      if (v > MAXV) v = MAXV;
      if (v >= t) begin
        s[i] = 1'b1;
        mem_m[i] = (RM != 0) ? 0 : v - t;
        ref_m[i] = RS;
      end else begin
        mem_m[i] = v;
      end
    end
    return s;
  endfunction

  function automatic logic [N*W-1:0] fill(input int v);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && spike_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_spike_valid: spikes=%b with no step outstanding", spikes);
      end else begin
        e_spk = exp_q.pop_front();
        check("spikes", int'(spikes), int'(e_spk));
      end
    end
  end

  task automatic issue_step(input logic [N*W-1:0] cur_v, input int b, input int t, input bit push);
    int n;
    @(negedge clk);
    current    = cur_v;
    beta       = W'(b);
    threshold  = W'(t);
    step_valid = 1'b1;
    n = 0;
    while (!step_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!step_ready) begin
      check("accept_timeout", 0, 1);
      step_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(model_step(cur_v, b, t));
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    for (int i = 0; i < N; i++) current[i*W +: W] = W'($urandom);
    beta      = W'($urandom);
    threshold = W'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !step_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_mems();
    for (int i = 0; i < N; i++) begin
      mon_sel = SW'(i);
      #1;
      check("state_mon", int'(state_mon), mem_m[i]);
    end
  endtask

  task automatic check_lit(input string name, input int idx, input int val);
    mon_sel = SW'(idx);
    #1;
    check(name, int'(state_mon), val);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  int prev;
  logic [N*W-1:0] cv;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("ready_after_reset", int'(step_ready), 1);
    check("valid_after_reset", int'(spike_valid), 0);
    check("spikes_after_reset", int'(spikes), 0);
    check_mems();

    // Latency: accept at edge 0, spike_valid present at edge N+1 only.
    issue_step(fill(60), 255, 200, 1'b1);
    for (int k = 1; k <= N + 2; k++) begin
      @(negedge clk);
      check("ready_cycle", int'(step_ready), (k >= N + 2) ? 1 : 0);
      check("valid_cycle", int'(spike_valid), (k == N + 1) ? 1 : 0);
    end
    wait_done();
    check_mems();
    check_lit("noleak_step1", 0, 60);
    for (int s = 2; s <= 4; s++) begin
      issue_step(fill(60), 255, 200, 1'b1);
      wait_done();
      check_mems();
    end
    check_lit("noleak_step4_mem", 0, 37);
    check("noleak_step4_spikes", int'(spikes), 4'hF);

    reset_dut();
    for (int s = 0; s < 2; s++) begin
      issue_step(fill(60), 0, 100, 1'b1);
      wait_done();
      check_lit("fullleak_60", 2, 60);
      check("fullleak_nospike", int'(spikes), 0);
    end
    issue_step(fill(150), 0, 100, 1'b1);
    wait_done();
    check_lit("fullleak_150", 0, (RM != 0) ? 0 : 50);
    check("fullleak_spike", int'(spikes), 4'hF);

    reset_dut();
    issue_step((N*W)'(250), 0, 255, 1'b1);
    wait_done();
    check_lit("sat_preload", 0, 250);
    issue_step((N*W)'(255), 255, 255, 1'b1);
    wait_done();
    check("sat_spikes", int'(spikes), 4'b0001);
    check_lit("sat_neighbour", 1, 0);
    check_mems();

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) cv[i*W +: W] = W'($urandom);
      issue_step(cv, int'($urandom_range(0, MAXV)),
                 ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MAXV)), 1'b1);
      wait_done();
      check_mems();
    end

    // step_valid held high: steps accepted every N+2 cycles.
    @(negedge clk);
    for (int i = 0; i < N; i++) current[i*W +: W] = W'($urandom_range(0, 90));
    beta       = W'($urandom_range(100, 250));
    threshold  = W'($urandom_range(80, 200));
    step_valid = 1'b1;
    prev = -1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (step_ready) begin
        exp_q.push_back(model_step(current, int'(beta), int'(threshold)));
        if (prev >= 0) check("b2b_spacing", c - prev, N + 2);
        prev = c;
      end
    end
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    wait_done();
    check_mems();

    // Reset mid-step: step aborted, no spike_valid, everything cleared.
    issue_step(fill(200), 200, 10, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    check("midrun_reset_spikes", int'(spikes), 0);
    check_mems();

`ifdef LIF_REFRACTORY_EN
    reset_dut();
    for (int s = 1; s <= 4; s++) begin
      issue_step(fill(255), 0, 100, 1'b1);
      wait_done();
      check("refrac_pattern", int'(spikes[0]), (s == 1 || s == 4) ? 1 : 0);
      check_lit("refrac_mem", 0, 155);
    end
`endif

    if (exp_q.size() != 0) check("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
